// File: rtl/synchronous_down_counter_if.sv
// Control/status bundle for the loadable down counter (count controls in, count status out).
// The width parameter N must match the counter instance it is connected to.
interface synchronous_down_counter_if #(
    parameter int N = 4
);
    logic         enable;
    logic         load;
    logic [N-1:0] D;
    logic         auto_reload;
    logic [N-1:0] Q;
    logic         tc;
    logic         busy;

    modport master (
        output enable,
        output load,
        output D,
        output auto_reload,
        input  Q,
        input  tc,
        input  busy
    );

    modport slave (
        input  enable,
        input  load,
        input  D,
        input  auto_reload,
        output Q,
        output tc,
        output busy
    );
endinterface

// File: rtl/synchronous_down_counter.sv
// Loadable N-bit synchronous down counter / interval timer with one-cycle terminal-count pulse.
// Optional periodic auto-reload is built only when SYNC_DOWN_COUNTER_AUTORELOAD_EN is defined.
module synchronous_down_counter #(
    parameter int N = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    synchronous_down_counter_if.slave     bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_count;
    logic         r_tc;
    logic         r_busy;

    logic         w_reload_active;
    logic [N-1:0] w_reload_value;
    logic         w_terminal;

`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
    logic [N-1:0] r_reload;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reload <= '0;
        end else if (bus.load) begin
            r_reload <= bus.D;
        end
    end

    // auto_reload is sampled at the terminal decrement itself, so mid-count changes only affect the next expiry.
    assign w_reload_active = bus.auto_reload && (r_reload != '0);
    assign w_reload_value  = r_reload;
`else
    assign w_reload_active = 1'b0;
    assign w_reload_value  = '0;
`endif

    // In RUN the count is always >= 1, so reaching 1 means this decrement expires the interval.
    assign w_terminal = (r_count == N'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
        end else if (bus.load) begin
            r_count <= bus.D;
            r_tc    <= 1'b0;
            if (bus.D != '0) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
            end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.enable) begin
                        if (w_terminal) begin
                            r_tc <= 1'b1;
                            if (w_reload_active) begin
                                r_count <= w_reload_value;
                            end else begin
                                r_count <= '0;
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_count <= r_count - N'(1);
                            r_tc    <= 1'b0;
                        end
                    end else begin
                        r_tc <= 1'b0;
                    end
                end
                default: begin
                    r_tc <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q    = r_count;
    assign bus.tc   = r_tc;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_synchronous_down_counter.sv
// Scoreboard bench for synchronous_down_counter: directed test-plan sequences then random stimulus,
// expectations from an elapsed-ticks model of the timer, compared by a separate negedge monitor.
module tb_synchronous_down_counter;

    localparam int N = 4;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
    localparam bit RELOAD_EN = 1'b1;
`else
    localparam bit RELOAD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] q;
        logic         tc;
        logic         busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    synchronous_down_counter_if #(.N(N)) bus_if ();

    synchronous_down_counter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    // Model: an active interval of length m_start, with m_ticks enabled cycles elapsed in it.
    int m_start  = 0;
    int m_ticks  = 0;
    bit m_active = 1'b0;
    bit m_tc     = 1'b0;

    task automatic step(input bit rst, input bit ld, input int d, input bit en, input bit ar);
        exp_t e;
        #1;
        reset              = rst;
        bus_if.load        = ld;
        bus_if.D           = N'(d);
        bus_if.enable      = en;
        bus_if.auto_reload = ar;
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0;
            m_start  = 0;
            m_ticks  = 0;
            m_tc     = 1'b0;
        end else if (ld) begin
            m_start  = d;
            m_ticks  = 0;
            m_active = (d != 0);
            m_tc     = 1'b0;
        end else if (m_active && en) begin
            m_ticks = m_ticks + 1;
            if (m_ticks == m_start) begin
                m_tc = 1'b1;
                if (RELOAD_EN && ar) m_ticks = 0;
                else m_active = 1'b0;
            end else begin
                m_tc = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
        e.q    = m_active ? N'(m_start - m_ticks) : '0;
        e.tc   = m_tc;
        e.busy = m_active;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks = checks + 1;
                if (bus_if.Q !== e.q || bus_if.tc !== e.tc || bus_if.busy !== e.busy) begin
                    errors = errors + 1;
                    $display("FAIL outputs cyc %0d: got Q=%0d tc=%b busy=%b, required Q=%0d tc=%b busy=%b",
                             cyc, bus_if.Q, bus_if.tc, bus_if.busy, e.q, e.tc, e.busy);
                end else begin
                    $display("cyc %0d Q=%0d tc=%b busy=%b ok", cyc, bus_if.Q, bus_if.tc, bus_if.busy);
                end
            end
        end
    end

    initial begin
        bit ar_rand;
        int wait_cnt;
        // Reset held with a competing load
        step(1, 1, 9, 0, 0);
        step(1, 1, 9, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        // One-shot from 5, then stays at 0
        step(0, 1, 5, 0, 0);
        repeat (16) step(0, 0, 0, 1, 0);
        // Enable gaps
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        // Load collides with terminal decrement
        step(0, 1, 4, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        step(0, 1, 7, 1, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        // Zero load
        step(0, 1, 0, 1, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        // Periodic, then auto_reload dropped mid-count
        step(0, 1, 3, 0, 1);
        repeat (9) step(0, 0, 0, 1, 1);
        repeat (5) step(0, 0, 0, 1, 0);
        // Reset mid-count
        step(0, 1, 9, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        // Random traffic
        ar_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) ar_rand = ~ar_rand;
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 11) == 0),
                 int'($urandom_range(0, (1 << N) - 1)),
                 ($urandom_range(0, 3) != 0),
                 ar_rand);
        end
        // Drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt = wait_cnt + 1;
        end
        #1;
        if (sb.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
